// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: elastic valid/ready stage register; reset/flush leaves RST_VAL on out_data. Option macro: PIPE_STAGE_SKID_EN.
// Latency: 1 cycle from input fire to out_valid/out_data; full throughput with out_ready held high.
// Backpressure: skid build holds one extra payload and registers in_ready; otherwise in_ready = !out_valid || out_ready.
module pipe_stage_reg #(
    parameter int unsigned      WIDTH   = 128,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       level
);

    logic             in_fire;
    logic             out_fire;
    logic [WIDTH-1:0] main_q;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

`ifdef PIPE_STAGE_SKID_EN
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic             in_ready_q;
    logic [WIDTH-1:0] skid_q;

    // in_ready comes straight from a flop so the stall path stops here.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != FULL);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (in_fire) state_d = BUSY;
            BUSY: begin
                if (in_fire && !out_fire)      state_d = FULL;
                else if (!in_fire && out_fire) state_d = EMPTY;
            end
            FULL:    if (out_fire) state_d = BUSY;
            default: state_d = EMPTY;
        endcase
    end

    always_comb begin
        out_valid = (state_q != EMPTY);
        in_ready  = in_ready_q;
        level     = (state_q == FULL) ? 2'd2 :
                    (state_q == BUSY) ? 2'd1 : 2'd0;
    end

    // main always feeds out_data; skid only catches the payload taken while out_ready was low.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            main_q <= RST_VAL;
            skid_q <= RST_VAL;
        end else begin
            if (in_fire && ((state_q == EMPTY) || out_fire))
                main_q <= in_data;
            else if ((state_q == FULL) && out_fire)
                main_q <= skid_q;
            if (in_fire && (state_q == BUSY) && !out_fire)
                skid_q <= in_data;
        end
    end
`else
    logic busy_q;
    logic busy_d;

    always_ff @(posedge clk) begin
        if (rst || flush) busy_q <= 1'b0;
        else              busy_q <= busy_d;
    end

    always_comb begin
        busy_d = busy_q;
        if (in_fire)       busy_d = 1'b1;
        else if (out_fire) busy_d = 1'b0;
    end

    always_comb begin
        out_valid = busy_q;
        in_ready  = !busy_q || out_ready;
        level     = {1'b0, busy_q};
    end

    always_ff @(posedge clk) begin
        if (rst || flush) main_q <= RST_VAL;
        else if (in_fire) main_q <= in_data;
    end
`endif

    assign out_data = main_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: vector tables, hand sequences for reset/flush, random traffic against a queue model.
`timescale 1ns/1ps
module tb_pipe_stage_reg;
    localparam int W = 128;
    localparam logic [W-1:0] RV = 128'h13;
`ifdef PIPE_STAGE_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif
    localparam logic [W-1:0] A = 128'h1133_2244;
    localparam logic [W-1:0] B = 128'h0133_2244;
    localparam logic [W-1:0] C = 128'h0033_2244;

    logic         clk = 1'b0;
    logic         rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0] in_data, out_data;
    logic [1:0]   level;
    int           tests = 0;
    int           fails = 0;

    pipe_stage_reg #(.WIDTH(W), .RST_VAL(RV)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .level(level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         iv;
        logic [W-1:0] d;
        logic         ordy;
        logic         fl;
        logic         e_ov;
        logic         e_ir;
        logic [1:0]   e_lvl;
        logic         chk_d;
        logic [W-1:0] e_d;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void add(input logic iv, input logic [W-1:0] d, input logic ordy, input logic fl,
                                input logic e_ov, input logic e_ir, input logic [1:0] e_lvl,
                                input logic chk_d, input logic [W-1:0] e_d);
        vec_t v;
        v.iv = iv; v.d = d; v.ordy = ordy; v.fl = fl;
        v.e_ov = e_ov; v.e_ir = e_ir; v.e_lvl = e_lvl; v.chk_d = chk_d; v.e_d = e_d;
        vecs.push_back(v);
    endfunction

    // Entered just after a rising edge; each row is one cycle, outputs checked mid-cycle.
    task automatic run_vecs(input string tag);
        for (int i = 0; i < vecs.size(); i++) begin
            in_valid  = vecs[i].iv;
            in_data   = vecs[i].d;
            out_ready = vecs[i].ordy;
            flush     = vecs[i].fl;
            rst       = 1'b0;
            @(negedge clk);
            chk($sformatf("%s[%0d].out_valid", tag, i), {127'b0, out_valid}, {127'b0, vecs[i].e_ov});
            chk($sformatf("%s[%0d].in_ready", tag, i), {127'b0, in_ready}, {127'b0, vecs[i].e_ir});
            chk($sformatf("%s[%0d].level", tag, i), {126'b0, level}, {126'b0, vecs[i].e_lvl});
            if (vecs[i].chk_d)
                chk($sformatf("%s[%0d].out_data", tag, i), out_data, vecs[i].e_d);
            @(posedge clk); #1;
        end
        vecs.delete();
    endtask

    logic [W-1:0] mq[$];
    logic         exp_ir, m_in, m_out;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset.out_valid", {127'b0, out_valid}, 128'd0);
        chk("reset.out_data", out_data, RV);
        chk("reset.level", {126'b0, level}, 128'd0);
        chk("reset.in_ready", {127'b0, in_ready}, 128'd1);
        @(posedge clk); #1;

        add(1, 128'h1234_4321, 1, 0, 0, 1, 0, 1, RV);
        add(1, 128'h0234_4321, 1, 0, 1, 1, 1, 1, 128'h1234_4321);
        add(1, 128'h0034_4321, 1, 0, 1, 1, 1, 1, 128'h0234_4321);
        add(0, 128'h0,         1, 0, 1, 1, 1, 1, 128'h0034_4321);
        add(0, 128'h0,         1, 0, 0, 1, 0, 0, 128'h0);
        run_vecs("stream");

`ifdef PIPE_STAGE_SKID_EN
        add(1, A, 1, 0, 0, 1, 0, 0, 0);
        add(1, B, 0, 0, 1, 1, 1, 1, A);
        add(0, 0, 0, 0, 1, 0, 2, 1, A);
        add(0, 0, 1, 0, 1, 0, 2, 1, A);
        add(0, 0, 1, 0, 1, 1, 1, 1, B);
        add(0, 0, 1, 0, 0, 1, 0, 0, 0);
`else
        add(1, A, 1, 0, 0, 1, 0, 0, 0);
        add(1, B, 0, 0, 1, 0, 1, 1, A);
        add(1, B, 0, 0, 1, 0, 1, 1, A);
        add(1, B, 1, 0, 1, 1, 1, 1, A);
        add(0, 0, 1, 0, 1, 1, 1, 1, B);
        add(0, 0, 1, 0, 0, 1, 0, 0, 0);
`endif
        run_vecs("backpressure");

        // Flush with a live input fire and an output fire in the same cycle.
        add(1, A, 0, 0, 0, 1, 0, 0, 0);
        add(1, C, 1, 1, 1, 1, 1, 1, A);
        add(0, 0, 1, 0, 0, 1, 0, 1, RV);
        add(0, 0, 1, 0, 0, 1, 0, 1, RV);
        run_vecs("flush_fire");

`ifdef PIPE_STAGE_SKID_EN
        add(1, A, 0, 0, 0, 1, 0, 0, 0);
        add(1, B, 0, 0, 1, 1, 1, 1, A);
        add(1, C, 0, 1, 1, 0, 2, 1, A);
        add(0, 0, 1, 0, 0, 1, 0, 1, RV);
        add(0, 0, 1, 0, 0, 1, 0, 1, RV);
        run_vecs("flush_full");
`endif

        // Reset while occupied, with a payload offered in the reset cycle.
        in_valid = 1'b1; in_data = A; out_ready = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1; in_data = C;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("rst_mid.out_valid", {127'b0, out_valid}, 128'd0);
        chk("rst_mid.level", {126'b0, level}, 128'd0);
        chk("rst_mid.out_data", out_data, RV);
        chk("rst_mid.in_ready", {127'b0, in_ready}, 128'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_mid.no_emit", {127'b0, out_valid}, 128'd0);
        @(posedge clk); #1;

        mq.delete();
        for (int c = 0; c < 10000; c++) begin
            rst       = ($urandom_range(0, 511) == 0);
            flush     = ($urandom_range(0, 63) == 0);
            in_valid  = $urandom_range(0, 1);
            out_ready = ($urandom_range(0, 3) != 0);
            in_data   = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            exp_ir = (CAP == 2) ? (mq.size() < 2) : ((mq.size() == 0) || out_ready);
            chk($sformatf("rand[%0d].level", c), {126'b0, level}, mq.size());
            chk($sformatf("rand[%0d].out_valid", c), {127'b0, out_valid}, {127'b0, mq.size() > 0});
            chk($sformatf("rand[%0d].in_ready", c), {127'b0, in_ready}, {127'b0, exp_ir});
            if (mq.size() > 0)
                chk($sformatf("rand[%0d].out_data", c), out_data, mq[0]);
            if (rst || flush) begin
                mq.delete();
            end else begin
                m_out = (mq.size() > 0) && out_ready;
                m_in  = in_valid && exp_ir;
                if (m_out) void'(mq.pop_front());
                if (m_in)  mq.push_back(in_data);
            end
            @(posedge clk); #1;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised elastic pipeline-stage register for the RISC-V pipeline. It replaces the plain enable-gated D flip-flop bank between stages (IF/ID, ID/EX, EX/MEM, MEM/WB). Data moves under a valid/ready handshake, a synchronous flush kills in-flight contents, and flushed or reset stages present a configurable bubble value. An optional two-entry skid buffer registers the upstream ready, which breaks the combinational stall path across stages.

## Interface
Parameters:
- WIDTH, 128: payload width in bits. Concatenated stage fields, e.g. {pc, rs1, rs2, inst}.
- RST_VAL, {WIDTH{1'b0}}: bubble value driven on out_data after reset or flush. For example, the IF/ID instance sets the inst field to NOP 32'h0000_0013.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  synchronous kill of all stored entries. Priority is below rst and above everything else.
- in_valid  in  1  upstream payload valid.
- in_ready  out  1  stage can accept this cycle.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  out_data holds a live payload.
- out_ready  in  1  downstream accepts this cycle.
- out_data  out  WIDTH  payload to the next stage.
- level  out  2  entries held: 0, 1 or 2.

## Operation
- Input fire: in_valid && in_ready. Output fire: out_valid && out_ready.
- Storage: a main register, which always drives out_data, and a skid register (skid build only). Payload order is strictly FIFO, and no payload is duplicated or lost except by flush.
- States (skid build): EMPTY (level 0), BUSY (level 1), FULL (level 2).
  - EMPTY: on input fire, main <= in_data and go to BUSY.
  - BUSY:
    - input fire with output fire: main <= in_data, stay in BUSY.
    - input fire without output fire: skid <= in_data, go to FULL.
    - output fire only: go to EMPTY.
    - otherwise: hold.
  - FULL: on output fire, main <= skid and go to BUSY. No input fire is possible in FULL.
- in_ready (skid build) is registered and equals (next state != FULL).
- Non-skid build: one register with states EMPTY and BUSY only.
  - in_ready = !out_valid || out_ready, combinational.
  - Main loads on input fire.
  - level never exceeds 1.
- out_valid = (state != EMPTY).
- Reset values when rst is high at an edge: state EMPTY, out_valid 0, level 0, main <= RST_VAL, skid <= RST_VAL. in_ready is 1 in the skid build. In the non-skid build in_ready is 1 by its equation.
- Flush has the same effect as reset on state, main and skid.
  - An input fire in the flush cycle is discarded.
  - An output fire in the flush cycle is still taken by downstream; the stage does not retract it.
- rst or flush mid-FULL drops both entries. No partial state survives.
- out_data is stable while out_valid && !out_ready.
- in_data is sampled only on input fire. Its value outside a fire is don't-care.

## Timing
- Latency: 1 cycle from input fire to out_valid/out_data.
- Throughput: 1 payload per cycle when out_ready is held high, in both builds.
- Skid build:
  - When out_ready drops, in_ready falls one cycle later.
  - The one payload accepted in that cycle lands in skid.
  - When out_ready returns, in_ready rises one cycle later (FULL→BUSY).
- Non-skid build: in_ready follows out_ready combinationally within the same cycle.
- level updates on the same edge as the state.

## Configuration
- PIPE_STAGE_SKID_EN defined: two-entry skid buffer, registered in_ready, and level ranges 0–2.
- Not defined: single-entry register, combinational in_ready, skid register and FULL state removed, and level[1] tied to 0.
- The port list is identical in both builds.

## Test plan
- Reset: with rst=1 for 2 cycles and RST_VAL=128'h13, expect out_valid=0, out_data=128'h13, level=0, in_ready=1 on the edge after rst is released.
- Streaming: in_valid=1 and out_ready=1, sending 12344321, 02344321, 00344321 (low bits, other fields zero) on consecutive cycles. Expect each on out_data exactly 1 cycle after its fire, with no bubbles.
- Backpressure, skid build:
  - Drop out_ready while sending A=1133_2244 then B=0133_2244. Expect level 2, in_ready=0, and out_data=A held.
  - Raise out_ready. Expect A out, then B, and in_ready=1 one cycle after A fires.
- Backpressure, non-skid build: the same stimulus gives in_ready=0 in the same cycle out_ready=0 with out_valid=1. B is accepted only after A fires.
- Flush in FULL with in_valid=1 and C=0033_2244 offered: the next cycle shows out_valid=0, level=0, out_data=RST_VAL, and C is never emitted.
- Random valid/ready for 10k cycles against a scoreboard: order is preserved, there is no loss or duplication, and out_data is stable under stall.
